adc_trig_encoder: RTL
=====================

// Module: adc_trig_encoder
// PURPOSE
//  Drives coded trigger sequences onto the ADC trigger line and checks the 16-bit raw data
//  stream returned by the ADC side. Two codes: ALIGN (1,0,1,0) and DELTA (1,0,0,1), one bit
//  per clk. Optionally waits for the 16'hFEFE align word on the raw bus and reports the
//  round-trip latency. Sits on the top CDT trigger side, facing the ADC raw-data generators.
// PARAMETERS
//  GUARD_CYC    6    clks trig held low after a code, before a new code (>=5 needed by receiver)
//  TIMEOUT_CYC  500  max clks waited for 16'hFEFE before flagging timeout (<=511)
// PORTS
//  clk              in   1   system clock
//  in_live          in   1   async active-low reset (0 = reset, 1 = live)
//  user_ena         in   1   enable; 0 aborts any operation to IDLE
//  cmd_align        in   1   1-clk request: send ALIGN code
//  cmd_delta        in   1   1-clk request: send DELTA code
//  in_raw           in   16  raw data returned by ADC side
//  out_adc_trig     out  1   registered coded trigger line
//  out_busy         out  1   1 while not IDLE
//  out_done         out  1   1-clk pulse at end of operation (success or timeout)
//  out_kind         out  1   code of last accepted cmd: 0 = ALIGN, 1 = DELTA
//  out_latency      out  9   measured latency in clks (valid with out_done, held after)
//  out_timeout_err  out  1   sticky: FEFE not seen within TIMEOUT_CYC
//  out_cmd_err      out  1   sticky: cmd dropped (busy, both cmds, or user_ena=0)
// BEHAVIOUR
//  Reset (in_live=0, async): all outputs 0, state IDLE, counters 0; mid-op reset drops trig at once.
//  States: IDLE -> SEND -> GUARD -> WAIT -> IDLE (WAIT only with LATENCY_CHECK_EN).
//  IDLE: accept cmd when user_ena=1. Both cmds same clk: ALIGN taken, out_cmd_err<=1.
//   Accept edge: out_kind<=code, out_busy<=1, bit idx<=0, go SEND.
//  SEND: 4 clks; out_adc_trig<=code[3-idx] each edge, MSB first (ALIGN 1010, DELTA 1001).
//   Edge loading the 4th bit = T0; lat_cnt<=0 there. Then go GUARD.
//  GUARD: out_adc_trig<=0 for GUARD_CYC clks; then WAIT (or IDLE + out_done if macro off).
//  WAIT: out_adc_trig=0. lat_cnt increments every edge after T0 (during GUARD and WAIT),
//   saturating at 511. FEFE detection is active in both GUARD and WAIT.
//   FEFE sampled at edge Ts: out_latency <= Ts-T0 in edges (lat_cnt+1); out_done pulse; go IDLE.
//   lat_cnt reaches TIMEOUT_CYC with no FEFE: out_timeout_err<=1, out_latency<=TIMEOUT_CYC,
//   out_done pulse, go IDLE.
//   Any raw value other than 16'hFEFE is ignored. FEFE seen in IDLE/SEND is ignored.
//  out_busy falls on the same edge that out_done rises; a cmd on that edge is dropped
//   (out_cmd_err<=1). Next cmd is accepted one clk later.
//  Cmd while busy: ignored, out_cmd_err<=1, current op unaffected.
//  user_ena=0: any state -> IDLE next edge, out_adc_trig<=0, no out_done; sticky flags held.
//   Cmd while user_ena=0: dropped, out_cmd_err<=1.
//  Sticky flags clear only on reset.
// CONFIGURATION
//  LATENCY_CHECK_EN defined: WAIT state, FEFE detection, latency/timeout as above.
//  Not defined: no WAIT; GUARD -> IDLE with out_done; out_latency and out_timeout_err tied 0;
//   in_raw unused.
// TESTING
//  cmd_align at edge 0 -> out_adc_trig 1,0,1,0 on edges 1-4, then 0; busy 1 from edge 0.
//  cmd_delta; bench returns FEFE 25 edges after T0 -> out_latency=25, out_done 1 clk, kind=1.
//  cmd_align, no FEFE -> out_done at T0+500, out_timeout_err=1, out_latency=500.
//  cmd_align+cmd_delta same clk -> ALIGN sent, out_cmd_err=1; 2nd cmd during SEND -> ignored.
//  in_live=0 during SEND bit 3 -> trig 0 immediately; all outputs 0; next cmd works normally.
//  user_ena=0 in WAIT -> IDLE, no out_done; late FEFE ignored; latency held from prior op.

Source files
------------

// File: rtl/adc_trig_encoder_if.sv
// -----------------------------------------------------------------------------
// adc_trig_encoder_if
// Purpose : groups the command/status signals of adc_trig_encoder.
// Signals : user_ena, cmd_align, cmd_delta, in_raw[15:0]      (master -> slave)
//           out_adc_trig, out_busy, out_done, out_kind,
//           out_latency[8:0], out_timeout_err, out_cmd_err    (slave -> master)
// Modports: master = controller/testbench side, slave = encoder side.
// -----------------------------------------------------------------------------
interface adc_trig_encoder_if;
    logic        user_ena;
    logic        cmd_align;
    logic        cmd_delta;
    logic [15:0] in_raw;
    logic        out_adc_trig;
    logic        out_busy;
    logic        out_done;
    logic        out_kind;
    logic [8:0]  out_latency;
    logic        out_timeout_err;
    logic        out_cmd_err;

    modport master (
        output user_ena, cmd_align, cmd_delta, in_raw,
        input  out_adc_trig, out_busy, out_done, out_kind,
               out_latency, out_timeout_err, out_cmd_err
    );

    modport slave (
        input  user_ena, cmd_align, cmd_delta, in_raw,
        output out_adc_trig, out_busy, out_done, out_kind,
               out_latency, out_timeout_err, out_cmd_err
    );
endinterface

// File: rtl/adc_trig_encoder.sv
// -----------------------------------------------------------------------------
// adc_trig_encoder
// Purpose : sends 4-bit coded triggers (ALIGN 1010, DELTA 1001, MSB first) on
//           the ADC trigger line, holds the line low for GUARD_CYC clks, and
//           optionally waits for the 16'hFEFE align word to report latency.
// Ports   : clk     - system clock
//           in_live - async active-low reset
//           bus     - adc_trig_encoder_if.slave (commands, raw data, status)
// Config  : define LATENCY_CHECK_EN to enable the WAIT state, FEFE detection,
//           latency measurement and timeout. Undefined: GUARD ends the op,
//           out_latency/out_timeout_err are tied 0 and in_raw is unused.
// -----------------------------------------------------------------------------
module adc_trig_encoder #(
    parameter int unsigned GUARD_CYC   = 6,
    parameter int unsigned TIMEOUT_CYC = 500
) (
    input  logic                  clk,
    input  logic                  in_live,
    adc_trig_encoder_if.slave     bus
);
    localparam int unsigned LAT_W  = 9;
    localparam int unsigned GCNT_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [3:0]  CODE_ALIGN = 4'b1010;
    localparam logic [3:0]  CODE_DELTA = 4'b1001;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GUARD, ST_WAIT} state_e;

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [GCNT_W-1:0]   guard_cnt_q, guard_cnt_d;
    logic                trig_q, trig_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                kind_q, kind_d;
    logic                cmd_err_q, cmd_err_d;

    logic                cmd_any, cmd_both, accept, cmd_err_set;
    logic                guard_last, finish;
    logic [3:0]          code;

    assign cmd_any     = bus.cmd_align | bus.cmd_delta;
    assign cmd_both    = bus.cmd_align & bus.cmd_delta;
    assign accept      = (state_q == ST_IDLE) & bus.user_ena & cmd_any;
    // Dropped commands (busy, disabled) and the losing half of a double command
    assign cmd_err_set = cmd_any & (~accept | cmd_both);
    assign guard_last  = (state_q == ST_GUARD) && (guard_cnt_q == GCNT_W'(GUARD_CYC - 1));
    assign code        = kind_q ? CODE_DELTA : CODE_ALIGN;

`ifdef LATENCY_CHECK_EN
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [LAT_W-1:0]    latency_q, latency_d;
    logic                tmo_q, tmo_d;
    logic [LAT_W-1:0]    lat_next;
    logic                det_active, fefe_hit, tmo_hit;

    assign det_active = (state_q == ST_GUARD) || (state_q == ST_WAIT);
    assign lat_next   = (lat_cnt_q == {LAT_W{1'b1}}) ? lat_cnt_q : lat_cnt_q + LAT_W'(1);
    assign fefe_hit   = det_active && (bus.in_raw == 16'hFEFE);
    // Timeout fires on the edge at which lat_cnt would reach TIMEOUT_CYC
    assign tmo_hit    = det_active && !fefe_hit &&
                        (({1'b0, lat_cnt_q} + 10'd1) >= 10'(TIMEOUT_CYC));
    assign finish     = bus.user_ena & (fefe_hit | tmo_hit);
`else
    logic unused_raw;
    assign unused_raw = ^bus.in_raw;
    assign finish     = bus.user_ena & guard_last;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge in_live) begin
        if (!in_live) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            guard_cnt_q <= '0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            kind_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
`ifdef LATENCY_CHECK_EN
            lat_cnt_q   <= '0;
            latency_q   <= '0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            guard_cnt_q <= guard_cnt_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            kind_q      <= kind_d;
            cmd_err_q   <= cmd_err_d;
`ifdef LATENCY_CHECK_EN
            lat_cnt_q   <= lat_cnt_d;
            latency_q   <= latency_d;
            tmo_q       <= tmo_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!bus.user_ena) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (accept) state_d = ST_SEND;
                ST_SEND:  if (idx_q == 2'd3) state_d = ST_GUARD;
                ST_GUARD: begin
                    if (finish) begin
                        state_d = ST_IDLE;
                    end else if (guard_last) begin
`ifdef LATENCY_CHECK_EN
                        state_d = ST_WAIT;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
                ST_WAIT:  if (finish) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Output and datapath next values
    always_comb begin
        trig_d      = trig_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        kind_d      = kind_q;
        idx_d       = idx_q;
        guard_cnt_d = guard_cnt_q;
        cmd_err_d   = cmd_err_q | cmd_err_set;
`ifdef LATENCY_CHECK_EN
        lat_cnt_d   = lat_cnt_q;
        latency_d   = latency_q;
        tmo_d       = tmo_q;
`endif
        if (!bus.user_ena) begin
            // Abort: no done pulse, sticky flags and latency held
            trig_d = 1'b0;
            busy_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    trig_d = 1'b0;
                    if (accept) begin
                        kind_d = ~bus.cmd_align;
                        busy_d = 1'b1;
                        idx_d  = '0;
                    end
                end
                ST_SEND: begin
                    trig_d = code[~idx_q];
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        guard_cnt_d = '0;
`ifdef LATENCY_CHECK_EN
                        lat_cnt_d   = '0;
`endif
                    end
                end
                ST_GUARD, ST_WAIT: begin
                    trig_d = 1'b0;
                    if (state_q == ST_GUARD && !guard_last) begin
                        guard_cnt_d = guard_cnt_q + GCNT_W'(1);
                    end
`ifdef LATENCY_CHECK_EN
                    lat_cnt_d = lat_next;
                    if (fefe_hit) begin
                        latency_d = lat_next;
                    end else if (tmo_hit) begin
                        tmo_d     = 1'b1;
                        latency_d = LAT_W'(TIMEOUT_CYC);
                    end
`endif
                    if (finish) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end
                default: trig_d = 1'b0;
            endcase
        end
    end

    assign bus.out_adc_trig    = trig_q;
    assign bus.out_busy        = busy_q;
    assign bus.out_done        = done_q;
    assign bus.out_kind        = kind_q;
    assign bus.out_cmd_err     = cmd_err_q;
`ifdef LATENCY_CHECK_EN
    assign bus.out_latency     = latency_q;
    assign bus.out_timeout_err = tmo_q;
`else
    assign bus.out_latency     = '0;
    assign bus.out_timeout_err = 1'b0;
`endif
endmodule
